// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants shared by the VGA timing path.
// Output bundle type used by vga_timing_gen.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;

    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT
                               + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT
                               + VGA_V_SYNC + VGA_V_BACK;

    typedef struct packed {
        logic [COORD_W-1:0] hpos;
        logic [COORD_W-1:0] vpos;
        logic               de;
        logic               hs;
        logic               vs;
        logic               ls;
        logic               fs;
        logic               vb;
        logic [7:0]         fc;
    } vga_out_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-N counter with enable, synchronous reset and wrap strobe.
// wrap is qualified by en so it can chain the next axis directly.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int N = VGA_H_TOTAL,
    parameter int W = COORD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign wrap = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: sync, display enable, coordinates and strobes.
// Define VGA_TIMING_OUTREG_EN to add one registered output stage.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_ce,
    output logic                hsync,
    output logic                vsync,
    output logic                display_on,
    output logic [COORD_W-1:0]  hpos,
    output logic [COORD_W-1:0]  vpos,
    output logic                line_start,
    output logic                frame_start,
    output logic                vblank_start,
    output logic [7:0]          frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int CW1     = COORD_W + 1;

    // One extra bit so window ends equal to 1024 still compare correctly
    localparam logic [CW1-1:0] H_DE = CW1'(H_DISPLAY);
    localparam logic [CW1-1:0] H_LO = CW1'(H_DISPLAY + H_FRONT);
    localparam logic [CW1-1:0] H_HI = CW1'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CW1-1:0] V_DE = CW1'(V_DISPLAY);
    localparam logic [CW1-1:0] V_LO = CW1'(V_DISPLAY + V_FRONT);
    localparam logic [CW1-1:0] V_HI = CW1'(V_DISPLAY + V_FRONT + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_wrap;
    logic               v_wrap;
    logic [7:0]         f_cnt;
    logic [CW1-1:0]     h_ext;
    logic [CW1-1:0]     v_ext;

    vga_axis_counter #(
        .N (H_TOTAL),
        .W (COORD_W)
    ) u_h_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (pix_ce),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .N (V_TOTAL),
        .W (COORD_W)
    ) u_v_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (h_wrap),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            f_cnt <= '0;
        end else if (v_wrap) begin
            f_cnt <= f_cnt + 8'd1;
        end
    end

    assign h_ext = {1'b0, h_cnt};
    assign v_ext = {1'b0, v_cnt};

    vga_out_t dec;
    vga_out_t obuf;

    always_comb begin
        dec    = '0;
        dec.hs = ~SYNC_POL;
        dec.vs = ~SYNC_POL;
        if (!reset) begin
            dec.hpos = h_cnt;
            dec.vpos = v_cnt;
            dec.fc   = f_cnt;
            dec.de   = (h_ext < H_DE) && (v_ext < V_DE);
            if (h_ext >= H_LO && h_ext < H_HI) begin
                dec.hs = SYNC_POL;
            end
            if (v_ext >= V_LO && v_ext < V_HI) begin
                dec.vs = SYNC_POL;
            end
            // Qualified by pix_ce so a divided enable yields one-clk pulses
            dec.ls = pix_ce && (h_cnt == '0);
            dec.fs = dec.ls && (v_cnt == '0);
            dec.vb = dec.ls && (v_ext == V_DE);
        end
    end

`ifdef VGA_TIMING_OUTREG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            obuf    <= '0;
            obuf.hs <= ~SYNC_POL;
            obuf.vs <= ~SYNC_POL;
        end else begin
            obuf <= dec;
        end
    end
`else
    assign obuf = dec;
`endif

    assign hpos         = obuf.hpos;
    assign vpos         = obuf.vpos;
    assign display_on   = obuf.de;
    assign hsync        = obuf.hs;
    assign vsync        = obuf.vs;
    assign line_start   = obuf.ls;
    assign frame_start  = obuf.fs;
    assign vblank_start = obuf.vb;
    assign frame_count  = obuf.fc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: small-raster scoreboard plus
// a default-timing instance for the 640x480 line windows.
module tb_vga_timing_gen;

    localparam int HD = 8, HF = 2, HS = 3, HB = 3, HT = 16;
    localparam int VD = 5, VF = 1, VS = 2, VB = 2, VT = 10;
    localparam bit POL = 1'b0;
`ifdef VGA_TIMING_OUTREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       pix_ce = 1'b0;
    logic       hsync, vsync, display_on;
    logic [9:0] hpos, vpos;
    logic       line_start, frame_start, vblank_start;
    logic [7:0] frame_count;

    logic       d_hsync, d_vsync, d_display_on;
    logic [9:0] d_hpos, d_vpos;
    logic       d_line_start, d_frame_start, d_vblank_start;
    logic [7:0] d_frame_count;

    vga_timing_gen #(
        .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .SYNC_POL  (POL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pix_ce       (pix_ce),
        .hsync        (hsync),
        .vsync        (vsync),
        .display_on   (display_on),
        .hpos         (hpos),
        .vpos         (vpos),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .vblank_start (vblank_start),
        .frame_count  (frame_count)
    );

    vga_timing_gen dut_def (
        .clk          (clk),
        .reset        (reset),
        .pix_ce       (pix_ce),
        .hsync        (d_hsync),
        .vsync        (d_vsync),
        .display_on   (d_display_on),
        .hpos         (d_hpos),
        .vpos         (d_vpos),
        .line_start   (d_line_start),
        .frame_start  (d_frame_start),
        .vblank_start (d_vblank_start),
        .frame_count  (d_frame_count)
    );

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       de, hs, vs, ls, fs, vb;
        logic [7:0] fc;
    } exp_t;

    typedef struct {
        logic r;
        logic ce;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    int         mh = 0, mv = 0;
    logic [7:0] mfc = 8'd0;

    bit mon = 0, dmon = 0;
    int fs_cnt, ls_cnt, vb_cnt, hs_act, vs_act, ls_double;
    logic prev_ls;
    int d_hs_cnt, d_hs_first, d_de_cnt, d_max_h;
    bit d_saw_wrap;

    function automatic exp_t mk(int h, int v, bit de, bit hs, bit vs,
                                bit ls, bit fs, bit vb, int fc);
        exp_t e;
        e.h = h[9:0]; e.v = v[9:0];
        e.de = de; e.hs = hs; e.vs = vs;
        e.ls = ls; e.fs = fs; e.vb = vb;
        e.fc = fc[7:0];
        return e;
    endfunction

    function automatic exp_t model_out(logic r, logic ce);
        exp_t e;
        e = '0;
        e.hs = ~POL;
        e.vs = ~POL;
        if (!r) begin
            e.h  = mh[9:0];
            e.v  = mv[9:0];
            e.fc = mfc;
            e.de = (mh < HD) && (mv < VD);
            if (mh >= HD + HF && mh < HD + HF + HS) e.hs = POL;
            if (mv >= VD + VF && mv < VD + VF + VS) e.vs = POL;
            e.ls = ce && (mh == 0);
            e.fs = e.ls && (mv == 0);
            e.vb = e.ls && (mv == VD);
        end
        return e;
    endfunction

    task automatic check(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic clr_stats();
        fs_cnt = 0; ls_cnt = 0; vb_cnt = 0;
        hs_act = 0; vs_act = 0; ls_double = 0;
        prev_ls = 1'b0;
        d_hs_cnt = 0; d_hs_first = -1; d_de_cnt = 0;
        d_max_h = 0; d_saw_wrap = 0;
    endtask

    task automatic step(logic r, logic ce, bit use_vec, exp_t vec);
        exp_t e, a, x;
        @(negedge clk);
        reset = r;
        pix_ce = ce;
        #1;
        e = use_vec ? vec : model_out(r, ce);
        sb.push_back(e);
        a = {hpos, vpos, display_on, hsync, vsync,
             line_start, frame_start, vblank_start, frame_count};
        if (sb.size() > LAT) begin
            x = sb.pop_front();
            checks++;
            if (a !== x) begin
                errors++;
                $display("FAIL sb cyc=%0d got h=%0d v=%0d f=%b fc=%0d want h=%0d v=%0d f=%b fc=%0d",
                         cyc, a.h, a.v, {a.de, a.hs, a.vs, a.ls, a.fs, a.vb}, a.fc,
                         x.h, x.v, {x.de, x.hs, x.vs, x.ls, x.fs, x.vb}, x.fc);
            end
        end
        if (mon) begin
            fs_cnt += int'(frame_start);
            ls_cnt += int'(line_start);
            vb_cnt += int'(vblank_start);
            hs_act += int'(hsync == POL);
            vs_act += int'(vsync == POL);
            if (line_start && prev_ls) ls_double++;
            prev_ls = line_start;
        end
        if (dmon) begin
            if (d_vpos == 10'd0) begin
                if (!d_hsync) begin
                    if (d_hs_cnt == 0) d_hs_first = int'(d_hpos);
                    d_hs_cnt++;
                end
                if (d_display_on) d_de_cnt++;
            end
            if (int'(d_hpos) > d_max_h) d_max_h = int'(d_hpos);
            if (d_vpos == 10'd1 && d_hpos == 10'd0) d_saw_wrap = 1;
        end
        @(posedge clk);
        cyc++;
        if (r) begin
            mh = 0; mv = 0; mfc = 8'd0;
        end else if (ce) begin
            if (mh == HT - 1) begin
                mh = 0;
                if (mv == VT - 1) begin
                    mv = 0;
                    mfc = mfc + 8'd1;
                end else begin
                    mv++;
                end
            end else begin
                mh++;
            end
        end
    endtask

    task automatic run(logic r, logic ce);
        step(r, ce, 1'b0, '0);
    endtask

    initial begin
        vec_t tbl[8];
        tbl[0] = '{r: 1'b1, ce: 1'b1, e: mk(0, 0, 0, 1, 1, 0, 0, 0, 0)};
        tbl[1] = '{r: 1'b1, ce: 1'b0, e: mk(0, 0, 0, 1, 1, 0, 0, 0, 0)};
        tbl[2] = '{r: 1'b0, ce: 1'b1, e: mk(0, 0, 1, 1, 1, 1, 1, 0, 0)};
        tbl[3] = '{r: 1'b0, ce: 1'b0, e: mk(1, 0, 1, 1, 1, 0, 0, 0, 0)};
        tbl[4] = '{r: 1'b0, ce: 1'b1, e: mk(1, 0, 1, 1, 1, 0, 0, 0, 0)};
        tbl[5] = '{r: 1'b0, ce: 1'b0, e: mk(2, 0, 1, 1, 1, 0, 0, 0, 0)};
        tbl[6] = '{r: 1'b0, ce: 1'b1, e: mk(2, 0, 1, 1, 1, 0, 0, 0, 0)};
        tbl[7] = '{r: 1'b0, ce: 1'b1, e: mk(3, 0, 1, 1, 1, 0, 0, 0, 0)};
        clr_stats();

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].r, tbl[i].ce, 1'b1, tbl[i].e);
        end

        // Continuous count over two frames plus a few pixels
        run(1'b1, 1'b1);
        clr_stats();
        mon = 1;
        repeat (325) run(1'b0, 1'b1);
        mon = 0;
        check("const_frame_start", fs_cnt, 3);
        check("const_line_start", ls_cnt, 21);
        check("const_vblank_start", vb_cnt, 2);
        check("const_hsync_active", hs_act, 60);
        check("const_vsync_active", vs_act, 64);

        // Divided enable: strobes must stay one clk wide
        run(1'b1, 1'b1);
        clr_stats();
        mon = 1;
        for (int i = 0; i < 650; i++) run(1'b0, (i % 2) == 0);
        mon = 0;
        check("tog_frame_start", fs_cnt, 3);
        check("tog_line_start", ls_cnt, 21);
        check("tog_vblank_start", vb_cnt, 2);
        check("tog_ls_double", ls_double, 0);

        // Reset in the middle of frame 2, inside the hsync window
        run(1'b1, 1'b1);
        repeat (HT * VT + 3 * HT + 11) run(1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, mk(11, 3, 0, POL, 1, 0, 0, 0, 1));
        step(1'b1, 1'b1, 1'b1, mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
        step(1'b0, 1'b1, 1'b1, mk(0, 0, 1, 1, 1, 1, 1, 0, 0));
        step(1'b0, 1'b1, 1'b1, mk(1, 0, 1, 1, 1, 0, 0, 0, 0));

        // 256 frames: frame_count wraps on the last pixel
        run(1'b1, 1'b1);
        repeat (256 * HT * VT - 1) run(1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, mk(15, 9, 0, 1, 1, 0, 0, 0, 255));
        step(1'b0, 1'b1, 1'b1, mk(0, 0, 1, 1, 1, 1, 1, 0, 0));
        step(1'b0, 1'b1, 1'b1, mk(1, 0, 1, 1, 1, 0, 0, 0, 0));

        // Default 640x480 timing: first line windows and line wrap
        run(1'b1, 1'b1);
        clr_stats();
        dmon = 1;
        repeat (1700) run(1'b0, 1'b1);
        dmon = 0;
        check("def_hsync_len", d_hs_cnt, 96);
        check("def_hsync_first", d_hs_first, 656);
        check("def_de_line0", d_de_cnt, 640);
        check("def_hpos_max", d_max_h, 799);
        check("def_line_wrap", int'(d_saw_wrap), 1);

        run(1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing (hsync, vsync, display enable, pixel coordinates) for the Game of Life display path.
- Sits directly upstream of the top-level pixel/colour logic, which consumes hpos/vpos/display_on.
- Also provides a one-cycle vblank_start strobe. The simulation controller uses it to start board updates only during blanking.
- Default timing is 640x480@60, one pixel per clk cycle when pix_ce=1.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, active sync level (0 = active-low, 1 = active-high), applies to both syncs

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- pix_ce  in  1  pixel clock enable; counters advance only when 1
- hsync  out  1  horizontal sync, polarity per SYNC_POL
- vsync  out  1  vertical sync, polarity per SYNC_POL
- display_on  out  1  high inside the visible area
- hpos  out  10  current column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- line_start  out  1  one-cycle strobe at hpos==0
- frame_start  out  1  one-cycle strobe at hpos==0 && vpos==0
- vblank_start  out  1  one-cycle strobe at hpos==0 && vpos==V_DISPLAY
- frame_count  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). Both must be ≤1024; an elaboration-time check fails otherwise.
- Horizontal counter: on clk with pix_ce=1, hpos increments. At hpos==H_TOTAL-1 it wraps to 0, and vpos increments (or wraps to 0 at V_TOTAL-1).
- pix_ce=0 holds all counters and frame_count.
- frame_count increments by 1 when hpos==H_TOTAL-1, vpos==V_TOTAL-1 and pix_ce=1. Arithmetic is 8-bit modulo.
- Decode:
  - display_on = (hpos<H_DISPLAY) && (vpos<V_DISPLAY).
  - hsync is active for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC), i.e. [656,752).
  - vsync is active for vpos in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC), i.e. [490,492).
  - Active level = SYNC_POL; inactive level = ~SYNC_POL.
- Strobes: each strobe = position match AND pix_ce. This gives exactly one clk-wide pulse per occurrence, even when pix_ce is a divided enable.
- Reset (synchronous, any cycle, including mid-frame):
  - hpos=0, vpos=0, frame_count=0.
  - display_on=0, all strobes=0, hsync/vsync=inactive level. These values are forced while reset=1.
- First cycle after reset deasserts with pix_ce=1: hpos=0, vpos=0, display_on=1, line_start=frame_start=1.
- Simultaneous events: at the last pixel of the frame, the hpos wrap, vpos wrap and frame_count increment occur in the same cycle. frame_start is asserted on the following pix_ce cycle.
- No state machine beyond the two wrap counters plus an optional output register stage. No handshake: all outputs are free-running.

Optional Feature:
- Macro VGA_TIMING_OUTREG_EN.
- Defined: hsync, vsync, display_on, hpos, vpos, strobes and frame_count are registered once more on clk, adding exactly 1 clk of latency relative to the counters. The register stage resets to the reset values above, so the first post-reset cycle still shows reset values and (0,0) appears on the second. Strobes remain one clk wide.
- Undefined: outputs are combinational decodes of the counter registers, with zero latency.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 timing constants (H_/V_ DISPLAY/FRONT/SYNC/BACK);
  - derived H_TOTAL/V_TOTAL;
  - the 10-bit coordinate width constant.
- One sub-module, vga_axis_counter: a parameterised modulo-N counter with enable, synchronous reset and wrap output. It is instantiated twice, for horizontal and vertical; the wrap output of the horizontal instance enables the vertical one.

Test Plan:
- Reset then pix_ce=1 constant for 800*525 cycles -> hpos wraps 799->0 every 800 cycles; vpos wraps 524->0; frame_count=1 after the frame; frame_start pulses exactly twice (first cycle and cycle 420000).
- Sync windows, SYNC_POL=0 -> hsync=0 exactly for hpos 656..751 (96 pixels); vsync=0 exactly for vpos 490..491; display_on=1 exactly for hpos<640 && vpos<480 (307200 active pixels per frame).
- pix_ce toggling 1,0,1,0 -> hpos advances every 2 clk; line_start/vblank_start each one clk wide; vblank_start once per frame at vpos=480.
- Reset asserted at hpos=400, vpos=300 -> next cycle hpos=0, vpos=0, frame_count=0, display_on=0, syncs inactive; normal count resumes after release.
- Run 256 frames -> frame_count wraps 255->0 on the last pixel of frame 256.
- VGA_TIMING_OUTREG_EN defined -> every output trails the undefined build by exactly 1 clk, compared cycle-by-cycle over one full frame.
